// File: rtl/model_ann_controller_weight_product.sv
// -----------------------------------------------------------------------------
// model_ann_controller_weight_product
//
// Computes one fully connected ANN layer: y[i] = b[i] + sum_j W[i][j] * x[j].
// The operands arrive as strobed element streams. The x vector is loaded once
// and buffered. For each row, the block accepts an optional bias and then J
// weights in row-major order. After the last weight of a row it emits y[i] one
// cycle later. All arithmetic wraps modulo 2^DATA_SIZE.
//
// Build option:
//   MODEL_ANN_CONTROLLER_BIAS_EN  defined   : each row starts in LOAD_B and
//                                             waits for a bias element.
//                                 undefined : the LOAD_B state is bypassed,
//                                             the accumulator starts each row
//                                             at 0, and B_IN_ENABLE/B_IN are
//                                             ignored.
//
// Ports:
//   CLK, RST                   clock, asynchronous active-high reset
//   START                      one-cycle request, honoured only in IDLE
//   SIZE_I_IN, SIZE_J_IN       row count I / column count J (latched on START)
//   X_IN_ENABLE, X_IN          input-vector element strobe / value
//   B_IN_ENABLE, B_IN          bias element strobe / value
//   W_IN_ENABLE, W_IN          weight element strobe / value (row-major)
//   DATA_OUT_ENABLE, DATA_OUT  result strobe / value y[i] (value held)
//   READY                      one-cycle pulse when the operation completes
// -----------------------------------------------------------------------------
module model_ann_controller_weight_product #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
  input  logic                    X_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    X_IN,
  input  logic                    B_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    B_IN,
  input  logic                    W_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    W_IN,
  output logic                    DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT
);

  typedef enum logic [1:0] {IDLE, LOAD_X, LOAD_B, ACCUM} state_t;

  localparam logic [CONTROL_SIZE-1:0] CTRL_ONE = CONTROL_SIZE'(1);

`ifdef MODEL_ANN_CONTROLLER_BIAS_EN
  localparam state_t ROW_START = LOAD_B;
`else
  localparam state_t ROW_START = ACCUM;
  // The bias ports are kept for interface compatibility but carry no function.
  logic unused_bias;
  assign unused_bias = ^{B_IN_ENABLE, B_IN};
`endif

  state_t                  state_q, state_d;
  logic [CONTROL_SIZE-1:0] size_i_q, size_i_d;
  logic [CONTROL_SIZE-1:0] size_j_q, size_j_d;
  logic [CONTROL_SIZE-1:0] i_q, i_d;
  logic [CONTROL_SIZE-1:0] j_q, j_d;
  logic [DATA_SIZE-1:0]    acc_q, acc_d;
  logic [DATA_SIZE-1:0]    dout_q, dout_d;
  logic                    dout_en_q, dout_en_d;
  logic                    ready_q, ready_d;

  logic                    x_we;
  logic [DATA_SIZE-1:0]    x_buf [2**CONTROL_SIZE];
  logic [DATA_SIZE-1:0]    product;
  logic [DATA_SIZE-1:0]    acc_sum;
  logic                    j_last;
  logic                    i_last;

  // The low DATA_SIZE bits of a product are the same for signed and unsigned
  // operands, so a plain same-width multiply gives the wrapped signed result.
  assign product = W_IN * x_buf[j_q];
  assign acc_sum = acc_q + product;
  assign j_last  = (j_q == size_j_q - CTRL_ONE);
  assign i_last  = (i_q == size_i_q - CTRL_ONE);

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    size_i_d  = size_i_q;
    size_j_d  = size_j_q;
    i_d       = i_q;
    j_d       = j_q;
    acc_d     = acc_q;
    dout_d    = dout_q;
    dout_en_d = 1'b0;
    ready_d   = 1'b0;
    x_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          size_i_d = SIZE_I_IN;
          size_j_d = SIZE_J_IN;
          i_d      = '0;
          j_d      = '0;
          acc_d    = '0;
          // Empty operation: finish at once with no result strobes.
          if (SIZE_I_IN == '0 || SIZE_J_IN == '0) ready_d = 1'b1;
          else                                    state_d = LOAD_X;
        end
      end

      LOAD_X: begin
        if (X_IN_ENABLE) begin
          x_we = 1'b1;
          if (j_last) begin
            j_d     = '0;
            acc_d   = '0;
            state_d = ROW_START;
          end else begin
            j_d = j_q + CTRL_ONE;
          end
        end
      end

      LOAD_B: begin
`ifdef MODEL_ANN_CONTROLLER_BIAS_EN
        if (B_IN_ENABLE) begin
          acc_d   = B_IN;
          j_d     = '0;
          state_d = ACCUM;
        end
`else
        acc_d   = '0;
        state_d = ACCUM;
`endif
      end

      ACCUM: begin
        if (W_IN_ENABLE) begin
          if (j_last) begin
            dout_d    = acc_sum;
            dout_en_d = 1'b1;
            j_d       = '0;
            acc_d     = '0;
            if (i_last) begin
              ready_d = 1'b1;
              state_d = IDLE;
            end else begin
              i_d     = i_q + CTRL_ONE;
              state_d = ROW_START;
            end
          end else begin
            acc_d = acc_sum;
            j_d   = j_q + CTRL_ONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from the same clock edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      size_i_q  <= '0;
      size_j_q  <= '0;
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_i_q  <= size_i_d;
      size_j_q  <= size_j_d;
      i_q       <= i_d;
      j_q       <= j_d;
      acc_q     <= acc_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      ready_q   <= ready_d;
    end
  end

  // NOTE: the x buffer has no reset. Every operation rewrites each entry it
  // reads before using it, so the content after reset does not matter.
  always_ff @(posedge CLK) begin
    if (x_we) x_buf[j_q] <= X_IN;
  end

  assign READY           = ready_q;
  assign DATA_OUT_ENABLE = dout_en_q;
  assign DATA_OUT        = dout_q;

endmodule

// File: tb/tb_model_ann_controller_weight_product.sv
// -----------------------------------------------------------------------------
// Testbench for model_ann_controller_weight_product.
// Drives randomized strobe streams with random idle gaps. Each result is
// compared with a reference computed directly as b[i] + sum_j W[i][j]*x[j]
// in 64-bit wrapping arithmetic.
// -----------------------------------------------------------------------------
module tb_model_ann_controller_weight_product;

  localparam int DW = 64;
  localparam int CW = 4;

`ifdef MODEL_ANN_CONTROLLER_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START = 1'b0;
  logic          READY;
  logic [CW-1:0] SIZE_I_IN = '0;
  logic [CW-1:0] SIZE_J_IN = '0;
  logic          X_IN_ENABLE = 1'b0;
  logic [DW-1:0] X_IN = '0;
  logic          B_IN_ENABLE = 1'b0;
  logic [DW-1:0] B_IN = '0;
  logic          W_IN_ENABLE = 1'b0;
  logic [DW-1:0] W_IN = '0;
  logic          DATA_OUT_ENABLE;
  logic [DW-1:0] DATA_OUT;

  always #5 CLK = ~CLK;

  model_ann_controller_weight_product #(.DATA_SIZE(DW), .CONTROL_SIZE(CW)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .START          (START),
    .READY          (READY),
    .SIZE_I_IN      (SIZE_I_IN),
    .SIZE_J_IN      (SIZE_J_IN),
    .X_IN_ENABLE    (X_IN_ENABLE),
    .X_IN           (X_IN),
    .B_IN_ENABLE    (B_IN_ENABLE),
    .B_IN           (B_IN),
    .W_IN_ENABLE    (W_IN_ENABLE),
    .W_IN           (W_IN),
    .DATA_OUT_ENABLE(DATA_OUT_ENABLE),
    .DATA_OUT       (DATA_OUT)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Output monitor: sampled on the falling edge, away from the active edge.
  int            cyc = 0;
  int            doe_cnt = 0;
  int            ready_cnt = 0;
  int            last_doe_cyc = -1;
  int            last_ready_cyc = -1;
  logic [DW-1:0] got_q[$];

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (DATA_OUT_ENABLE === 1'b1) begin
      got_q.push_back(DATA_OUT);
      doe_cnt++;
      last_doe_cyc = cyc;
    end
    if (READY === 1'b1) begin
      ready_cnt++;
      last_ready_cyc = cyc;
    end
  end

  // Operand storage shared by stimulus and reference model.
  logic [DW-1:0] xv [15];
  logic [DW-1:0] bv [15];
  logic [DW-1:0] wv [15][15];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: y[i] = b[i] (or 0) + sum_j W[i][j]*x[j], modulo 2^64.
  function automatic logic [DW-1:0] model_y(int i, int nj);
    logic [DW-1:0] acc;
    acc = BIAS_EN ? bv[i] : '0;
    for (int j = 0; j < nj; j++) acc = acc + wv[i][j] * xv[j];
    return acc;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic gap(int gmax);
    int n;
    n = $urandom_range(gmax, 0);
    repeat (n) tick();
  endtask

  task automatic clear_strobes();
    START       = 1'b0;
    X_IN_ENABLE = 1'b0;
    B_IN_ENABLE = 1'b0;
    W_IN_ENABLE = 1'b0;
  endtask

  task automatic drive_start(int ni, int nj);
    START     = 1'b1;
    SIZE_I_IN = CW'(ni);
    SIZE_J_IN = CW'(nj);
    tick();
    clear_strobes();
  endtask

  // Loads x; garbage weight/bias strobes arrive alongside and must be ignored.
  task automatic drive_x(int nj, int gmax);
    for (int j = 0; j < nj; j++) begin
      gap(gmax);
      X_IN_ENABLE = 1'b1;
      X_IN        = xv[j];
      W_IN_ENABLE = 1'($urandom % 2);
      W_IN        = rnd64();
      B_IN_ENABLE = 1'($urandom % 2);
      B_IN        = rnd64();
      tick();
      clear_strobes();
    end
  endtask

  // One row: a bias strobe, then nw weights. Garbage strobes are driven
  // alongside wherever the design must ignore them.
  task automatic drive_row(int i, int nw, int gmax, bit inj_start);
    gap(gmax);
    B_IN_ENABLE = 1'b1;
    B_IN        = bv[i];
    if (BIAS_EN) begin
      W_IN_ENABLE = 1'($urandom % 2);
      W_IN        = rnd64();
    end
    tick();
    clear_strobes();
    for (int j = 0; j < nw; j++) begin
      gap(gmax);
      W_IN_ENABLE = 1'b1;
      W_IN        = wv[i][j];
      X_IN_ENABLE = 1'($urandom % 2);
      X_IN        = rnd64();
      B_IN_ENABLE = 1'($urandom % 2);
      B_IN        = rnd64();
      if (inj_start && j == 0) begin
        START     = 1'b1;
        SIZE_I_IN = CW'(2);
        SIZE_J_IN = CW'(3);
      end
      tick();
      clear_strobes();
    end
  endtask

  task automatic wait_ready(input string name, input int base);
    int k;
    k = 0;
    while (ready_cnt == base && k < 300) begin
      tick();
      k++;
    end
    check({name, " ready seen"}, DW'(ready_cnt != base), DW'(1));
  endtask

  task automatic run_op(input string name, input int ni, input int nj,
                        input int gmax, input bit inj_start);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] g;
    int base_r;
    int base_d;
    base_r = ready_cnt;
    base_d = doe_cnt;
    got_q.delete();
    for (int i = 0; i < ni; i++) exp_q.push_back(model_y(i, nj));
    gap(gmax);
    drive_start(ni, nj);
    drive_x(nj, gmax);
    for (int i = 0; i < ni; i++) drive_row(i, nj, gmax, inj_start && i == 0);
    wait_ready(name, base_r);
    repeat (4) tick();
    check({name, " pulse count"}, DW'(doe_cnt - base_d), DW'(ni));
    check({name, " ready count"}, DW'(ready_cnt - base_r), DW'(1));
    check({name, " ready with last"}, DW'(last_ready_cyc), DW'(last_doe_cyc));
    for (int i = 0; i < ni; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      check($sformatf("%s y[%0d]", name, i), g, exp_q[i]);
    end
    check({name, " data hold"}, DATA_OUT, exp_q[ni-1]);
  endtask

  task automatic zero_op(input string name, input int ni, input int nj);
    int base_d;
    base_d = doe_cnt;
    drive_start(ni, nj);
    @(negedge CLK);
    check({name, " ready"}, DW'(READY), DW'(1));
    check({name, " no pulse"}, DW'(DATA_OUT_ENABLE), DW'(0));
    tick();
    @(negedge CLK);
    check({name, " ready drop"}, DW'(READY), DW'(0));
    tick();
    check({name, " pulse count"}, DW'(doe_cnt - base_d), DW'(0));
  endtask

  task automatic randomize_operands();
    for (int a = 0; a < 15; a++) begin
      xv[a] = rnd64();
      bv[a] = rnd64();
      for (int b = 0; b < 15; b++) wv[a][b] = rnd64();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] y0;
    int base_d;
    int base_r;

    // Reset state, observed while reset is held and before any clock edge.
    #1 RST = 1'b1;
    #2;
    check("reset ready", DW'(READY), DW'(0));
    check("reset doe", DW'(DATA_OUT_ENABLE), DW'(0));
    check("reset data", DATA_OUT, DW'(0));
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    tick();

    // Small worked example.
    randomize_operands();
    xv[0] = 64'd1;  xv[1] = 64'd2;  xv[2] = 64'd3;
    bv[0] = 64'd10; bv[1] = 64'd20;
    wv[0][0] = 64'd1; wv[0][1] = 64'd1; wv[0][2] = 64'd1;
    wv[1][0] = 64'd2; wv[1][1] = 64'd0; wv[1][2] = '1;
    run_op("basic", 2, 3, 0, 1'b0);
    if (got_q.size() == 2) begin
      check("basic y0 const", got_q[0], BIAS_EN ? DW'(16) : DW'(6));
      check("basic y1 const", got_q[1], BIAS_EN ? DW'(19) : '1);
    end else begin
      check("basic result count", DW'(got_q.size()), DW'(2));
    end

    // Wrap: 2^62 * 4 = 2^64, which is 0 modulo 2^64.
    xv[0]    = 64'h4000_0000_0000_0000;
    wv[0][0] = 64'd4;
    bv[0]    = 64'd7;
    run_op("wrap", 1, 1, 1, 1'b0);
    check("wrap const", DATA_OUT, BIAS_EN ? DW'(7) : DW'(0));

    // Empty operations.
    zero_op("zero_i", 0, 5);
    zero_op("zero_j", 5, 0);

    // Full-size run with gaps and a START that must be ignored in ACCUM.
    randomize_operands();
    run_op("full_inj", 15, 15, 5, 1'b1);

    // Reset in the middle of row 1 of a three-row operation.
    randomize_operands();
    got_q.delete();
    y0 = model_y(0, 4);
    drive_start(3, 4);
    drive_x(4, 2);
    drive_row(0, 4, 2, 1'b0);
    drive_row(1, 2, 2, 1'b0);
    check("pre-reset y0", (got_q.size() > 0) ? got_q[0] : 'x, y0);
    #2 RST = 1'b1;
    #1;
    check("async rst data", DATA_OUT, DW'(0));
    check("async rst doe", DW'(DATA_OUT_ENABLE), DW'(0));
    check("async rst ready", DW'(READY), DW'(0));
    base_d = doe_cnt;
    base_r = ready_cnt;
    tick();
    tick();
    RST = 1'b0;
    for (int j = 0; j < 3; j++) begin
      W_IN_ENABLE = 1'b1;
      W_IN        = rnd64();
      tick();
      clear_strobes();
    end
    repeat (5) tick();
    check("post-rst no pulse", DW'(doe_cnt - base_d), DW'(0));
    check("post-rst no ready", DW'(ready_cnt - base_r), DW'(0));
    run_op("after_rst", 3, 4, 2, 1'b0);

    // Random sizes and values.
    for (int t = 0; t < 4; t++) begin
      randomize_operands();
      run_op($sformatf("rand%0d", t), $urandom_range(15, 1), $urandom_range(15, 1), 3, 1'b0);
    end

    // Full-size run with gaps of 0 to 5 idle cycles.
    randomize_operands();
    run_op("full", 15, 15, 5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/model_ann_controller_weight_product.md
MODEL_ANN_CONTROLLER_WEIGHT_PRODUCT -- requirements
Module: model_ann_controller_weight_product

Interface
REQ-001 Parameter DATA_SIZE, 64, width of every data word (two's-complement integer).
REQ-002 Parameter CONTROL_SIZE, 4, width of size fields; max vector length 2^CONTROL_SIZE-1 = 15.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 START  input  1  one-cycle request to begin an operation.
REQ-006 READY  output  1  one-cycle pulse: operation complete.
REQ-007 SIZE_I_IN  input  CONTROL_SIZE  row count I (output vector length).
REQ-008 SIZE_J_IN  input  CONTROL_SIZE  column count J (input vector length).
REQ-009 X_IN_ENABLE / X_IN  input  1 / DATA_SIZE  input-vector element strobe/value.
REQ-010 B_IN_ENABLE / B_IN  input  1 / DATA_SIZE  bias element strobe/value.
REQ-011 W_IN_ENABLE / W_IN  input  1 / DATA_SIZE  weight element strobe/value, row-major.
REQ-012 DATA_OUT_ENABLE / DATA_OUT  output  1 / DATA_SIZE  result element strobe/value y[i].

Function
REQ-013 Block SHALL compute y[i] = b[i] + sum over j of W[i][j]*x[j], i = 0..I-1, j = 0..J-1, emitting y in ascending i.
REQ-014 FSM states SHALL be IDLE, LOAD_X, LOAD_B, ACCUM; IDLE on reset.
REQ-015 IDLE: START=1 latches SIZE_I_IN/SIZE_J_IN, clears counters and goes to LOAD_X; START outside IDLE SHALL be ignored.
REQ-016 LOAD_X: each X_IN_ENABLE cycle stores X_IN into internal buffer at index j, j increments; after J-th element go to LOAD_B.
REQ-017 LOAD_B: B_IN_ENABLE loads accumulator with B_IN, clears j, goes to ACCUM; W_IN_ENABLE in the same cycle SHALL be ignored.
REQ-018 ACCUM: each W_IN_ENABLE cycle adds W_IN*x[j] to accumulator, j increments; strobes on other inputs ignored.
REQ-019 Product SHALL be taken as low DATA_SIZE bits of the full signed product; sums wrap modulo 2^DATA_SIZE, no saturation.
REQ-020 The cycle after the J-th weight of row i is accepted, DATA_OUT_ENABLE SHALL pulse for exactly one cycle with DATA_OUT = y[i] (latency 1); DATA_OUT holds value until next pulse.
REQ-021 If i < I-1 after output, i increments and FSM returns to LOAD_B; the buffered x SHALL be reused unchanged for all rows.
REQ-022 After row I-1, READY SHALL pulse in the same cycle as the final DATA_OUT_ENABLE and FSM returns to IDLE.
REQ-023 SIZE_I=0 or SIZE_J=0 at START: no DATA_OUT_ENABLE, READY pulses the next cycle, back to IDLE.
REQ-024 Strobes with enable low SHALL not advance any counter; gaps between strobes of any length are legal.

Reset
REQ-025 RST=1 SHALL immediately force IDLE, READY=0, DATA_OUT_ENABLE=0, DATA_OUT=0, counters and accumulator 0, independent of CLK.
REQ-026 Reset mid-operation SHALL abandon the operation with no further output; x buffer content is don't-care after reset.

Configuration
REQ-027 Macro MODEL_ANN_CONTROLLER_BIAS_EN: when defined, LOAD_B behaves per REQ-017.
REQ-028 When undefined, LOAD_B SHALL be bypassed, accumulator cleared to 0 at each row start, B_IN_ENABLE/B_IN ignored; ports still present.

Verification
REQ-029 I=2, J=3, x={1,2,3}, b={10,20}, W={1,1,1, 2,0,-1} -> DATA_OUT 16 then 19, READY with second pulse (bias enabled).
REQ-030 Same stimulus, macro undefined -> DATA_OUT 6 then -1; B_IN strobes have no effect.
REQ-031 I=1, J=1, x=2^62, W=4 -> DATA_OUT = 0 plus bias (wrap), single pulse, READY.
REQ-032 I=0, J=5, START -> READY one cycle later, no DATA_OUT_ENABLE; second START in ACCUM of a 15x15 run ignored.
REQ-033 RST asserted mid-ACCUM of row 1 of I=3 run -> outputs 0 asynchronously, no further pulses; new START runs correctly.
REQ-034 Random gaps (0-5 idle cycles) between all strobes, I=J=15 -> results match reference model element-wise.
